// File: rtl/jbi_dbg_pkg.sv
// Shared types and constants for the JBI debug-queue drain path.
// Marker insertion is enabled by defining JBI_DBG_DRAIN_MARK_EN.
package jbi_dbg_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_HI   = 2'd1,
        ST_LO   = 2'd2,
        ST_MK   = 2'd3
    } dbg_state_e;

    localparam logic [15:0] MARK_TAG   = 16'hF00D;
    localparam int          BEAT_W_DEF = 64;

endpackage

// File: rtl/jbi_dbg_drop_cnt.sv
// Saturating count of pushes lost to DBGQ overflow.
// Used only when JBI_DBG_DRAIN_MARK_EN is defined; clr with inc yields 1.
module jbi_dbg_drop_cnt #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc,
    input  logic             clr,
    output logic [CNT_W-1:0] cnt
);

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= CNT_W'(inc);
        end else if (inc && (cnt != '1)) begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/jbi_dbg_ctl_drain.sv
// DBGQ drain: splits each entry into HI/LO half-width beats on a valid/ready port.
// Define JBI_DBG_DRAIN_MARK_EN to insert drop-count marker beats.
module jbi_dbg_ctl_drain
    import jbi_dbg_pkg::*;
#(
    parameter int DATA_W = 2 * BEAT_W_DEF,
    parameter int CNT_W  = 16
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                dbg_en,
    input  logic                empty,
    input  logic [DATA_W-1:0]   rdata,
    input  logic                overflow,
    output logic                pop,
    output logic                dbg_vld,
    input  logic                dbg_rdy,
    output logic [DATA_W/2-1:0] dbg_data,
    output logic                busy
);

    localparam int BEAT_W = DATA_W / 2;

    dbg_state_e        state;
    dbg_state_e        state_nxt;
    logic [BEAT_W-1:0] data_nxt;
    logic [BEAT_W-1:0] mark_beat;
    logic              load;
    logic              mark_req;

    assign load = (state == ST_IDLE) | (dbg_vld & dbg_rdy);
    assign pop  = load & (state == ST_HI);

`ifdef JBI_DBG_DRAIN_MARK_EN
    logic [CNT_W-1:0] drop_cnt;
    logic             mark_load;

    assign mark_req  = dbg_en & (drop_cnt != '0);
    assign mark_load = load & (state != ST_HI) & mark_req;

    jbi_dbg_drop_cnt #(
        .CNT_W(CNT_W)
    ) u_drop_cnt (
        .clk(clk),
        .rst(rst),
        .inc(overflow),
        .clr(mark_load),
        .cnt(drop_cnt)
    );

    always_comb begin
        mark_beat                  = '0;
        mark_beat[BEAT_W-1 -: 16]  = MARK_TAG;
        mark_beat[CNT_W-1:0]       = drop_cnt;
    end
`else
    logic unused_overflow;

    assign unused_overflow = overflow;
    assign mark_req        = 1'b0;
    assign mark_beat       = '0;
`endif

    // An entry in flight always finishes before markers or new entries.
    always_comb begin
        state_nxt = ST_IDLE;
        data_nxt  = '0;
        priority case (1'b1)
            (state == ST_HI): begin
                state_nxt = ST_LO;
                data_nxt  = rdata[BEAT_W-1:0];
            end
            mark_req: begin
                state_nxt = ST_MK;
                data_nxt  = mark_beat;
            end
            (dbg_en & ~empty): begin
                state_nxt = ST_HI;
                data_nxt  = rdata[DATA_W-1:BEAT_W];
            end
            default: begin
                state_nxt = ST_IDLE;
                data_nxt  = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= ST_IDLE;
            dbg_vld  <= 1'b0;
            dbg_data <= '0;
            busy     <= 1'b0;
        end else if (load) begin
            state    <= state_nxt;
            dbg_vld  <= (state_nxt != ST_IDLE);
            dbg_data <= data_nxt;
            busy     <= (state_nxt != ST_IDLE);
        end
    end

endmodule

// File: tb/tb_jbi_dbg_ctl_drain.sv
// Scoreboard bench for jbi_dbg_ctl_drain with a queue model of the DBGQ.
// Marker tests run when JBI_DBG_DRAIN_MARK_EN is defined.
module tb_jbi_dbg_ctl_drain;

    typedef struct {
        logic [63:0] data;
        logic        is_hi;
    } beat_t;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         dbg_en = 1'b0;
    logic         empty = 1'b1;
    logic [127:0] rdata = '0;
    logic         overflow = 1'b0;
    logic         pop;
    logic         dbg_vld;
    logic         dbg_rdy = 1'b0;
    logic [63:0]  dbg_data;
    logic         busy;

    logic [127:0] dbgq[$];
    logic [127:0] push_pend[$];
    beat_t        exp_q[$];

    int n_tests = 0;
    int n_fail  = 0;
    int n_pop   = 0;
    int n_push  = 0;

    logic        prev_stall = 1'b0;
    logic [63:0] prev_data  = '0;

    jbi_dbg_ctl_drain #(
        .DATA_W(128),
        .CNT_W (16)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .dbg_en  (dbg_en),
        .empty   (empty),
        .rdata   (rdata),
        .overflow(overflow),
        .pop     (pop),
        .dbg_vld (dbg_vld),
        .dbg_rdy (dbg_rdy),
        .dbg_data(dbg_data),
        .busy    (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [127:0] act,
                       input logic [127:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Queue control model: new head appears one cycle after pop.
    always @(posedge clk) begin
        if (pop && !rst && dbgq.size() > 0)
            void'(dbgq.pop_front());
        foreach (push_pend[i])
            dbgq.push_back(push_pend[i]);
        push_pend.delete();
        empty <= (dbgq.size() == 0);
        rdata <= (dbgq.size() > 0) ? dbgq[0] : '0;
    end

    always @(negedge clk) begin
        beat_t e;
        if (!rst) begin
            if (dbg_vld && dbg_rdy) begin
                if (exp_q.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL unexpected_beat: got %h expected none",
                             dbg_data);
                end else begin
                    e = exp_q.pop_front();
                    chk("beat_data", dbg_data, e.data);
                    chk("pop_on_hi", pop, e.is_hi);
                end
            end else begin
                chk("pop_no_accept", pop, 0);
            end
            if (pop) begin
                n_pop++;
                chk("pop_nonempty", empty, 0);
            end
            chk("busy_vld", busy, dbg_vld);
            if (prev_stall) begin
                chk("stall_vld", dbg_vld, 1);
                chk("stall_data", dbg_data, prev_data);
            end
            prev_stall = dbg_vld & ~dbg_rdy;
            prev_data  = dbg_data;
        end else begin
            prev_stall = 1'b0;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [127:0] e);
        push_pend.push_back(e);
        exp_q.push_back('{data: e[127:64], is_hi: 1'b1});
        exp_q.push_back('{data: e[63:0], is_hi: 1'b0});
        n_push++;
    endtask

    task automatic exp_mark(input logic [15:0] n);
        exp_q.push_back('{data: {16'hF00D, 32'h0, n}, is_hi: 1'b0});
    endtask

    task automatic wait_vld(input int budget);
        bit seen = 0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (dbg_vld) begin
                seen = 1;
                break;
            end
        end
        if (!seen) chk("wait_vld_timeout", 0, 1);
    endtask

    task automatic drain(input int budget);
        bit done = 0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (exp_q.size() == 0 && !dbg_vld) begin
                done = 1;
                break;
            end
        end
        if (!done) chk("drain_timeout", exp_q.size(), 0);
    endtask

    function automatic logic [127:0] rnd128();
        return {$urandom(), $urandom(), $urandom(), $urandom()};
    endfunction

    initial begin
        int           p0;
        int           gaps;
        logic [127:0] ent;

        repeat (3) tick();
        @(negedge clk);
        chk("rst_vld", dbg_vld, 0);
        chk("rst_data", dbg_data, 0);
        chk("rst_busy", busy, 0);
        chk("rst_pop", pop, 0);
        tick();
        rst = 1'b0;

        // single entry, latency and single pop
        dbg_en  = 1'b1;
        dbg_rdy = 1'b1;
        p0 = n_pop;
        push({64'h1111_1111_1111_1111, 64'h2222_2222_2222_2222});
        tick();
        @(negedge clk);
        chk("lat_empty", empty, 0);
        chk("lat_vld0", dbg_vld, 0);
        tick();
        @(negedge clk);
        chk("lat_hi_vld", dbg_vld, 1);
        chk("lat_hi_data", dbg_data, 64'h1111_1111_1111_1111);
        tick();
        @(negedge clk);
        chk("lat_lo_data", dbg_data, 64'h2222_2222_2222_2222);
        tick();
        @(negedge clk);
        chk("one_idle_vld", dbg_vld, 0);
        chk("one_idle_busy", busy, 0);
        chk("one_pops", n_pop - p0, 1);

        // three entries back to back
        tick();
        p0 = n_pop;
        for (int i = 0; i < 3; i++) push(rnd128());
        wait_vld(10);
        gaps = 0;
        repeat (5) begin
            @(negedge clk);
            if (!dbg_vld) gaps++;
        end
        chk("b2b_gaps", gaps, 0);
        @(negedge clk);
        chk("b2b_idle", dbg_vld, 0);
        chk("b2b_pops", n_pop - p0, 3);

        // backpressure during HI
        tick();
        dbg_rdy = 1'b0;
        ent = rnd128();
        push(ent);
        wait_vld(10);
        p0 = n_pop;
        repeat (5) @(negedge clk);
        chk("bp_pops", n_pop - p0, 0);
        chk("bp_hold", dbg_data, ent[127:64]);
        tick();
        dbg_rdy = 1'b1;
        @(negedge clk);
        tick();
        @(negedge clk);
        chk("bp_lo", dbg_data, ent[63:0]);
        drain(20);

        // dbg_en drops while LO is presented
        tick();
        push(rnd128());
        push(rnd128());
        wait_vld(10);
        tick();
        dbg_en = 1'b0;
        @(negedge clk);
        chk("en_lo_vld", dbg_vld, 1);
        repeat (3) begin
            @(negedge clk);
            chk("en_idle_vld", dbg_vld, 0);
        end
        chk("en_pending", exp_q.size(), 2);
        tick();
        dbg_en = 1'b1;
        drain(20);

        // reset while HI is presented
        tick();
        dbg_rdy = 1'b0;
        push(rnd128());
        wait_vld(10);
        p0 = n_pop;
        tick();
        rst = 1'b1;
        @(negedge clk);
        chk("rst_hi_pop", pop, 0);
        tick();
        rst = 1'b0;
        @(negedge clk);
        chk("rst_hi_vld", dbg_vld, 0);
        chk("rst_hi_pops", n_pop - p0, 0);
        tick();
        dbg_rdy = 1'b1;
        drain(20);

`ifdef JBI_DBG_DRAIN_MARK_EN
        tick();
        dbg_en = 1'b0;
        repeat (3) begin
            tick();
            overflow = 1'b1;
            tick();
            overflow = 1'b0;
        end
        exp_mark(16'd3);
        push(rnd128());
        tick();
        dbg_en = 1'b1;
        drain(20);
        repeat (4) begin
            @(negedge clk);
            chk("mk_cleared", dbg_vld, 0);
        end

        tick();
        dbg_en   = 1'b0;
        overflow = 1'b1;
        repeat (70000) tick();
        exp_mark(16'hFFFF);
        exp_mark(16'd1);
        dbg_en = 1'b1;
        tick();
        overflow = 1'b0;
        drain(20);
        repeat (4) begin
            @(negedge clk);
            chk("mk_sat_quiet", dbg_vld, 0);
        end
`endif

        // randomized traffic
        for (int it = 0; it < 3000; it++) begin
            tick();
            dbg_rdy = ($urandom_range(0, 3) != 0);
            dbg_en  = ($urandom_range(0, 7) != 0);
            if ($urandom_range(0, 2) == 0) push(rnd128());
`ifndef JBI_DBG_DRAIN_MARK_EN
            overflow = $urandom_range(0, 1) != 0;
`endif
        end
        tick();
        dbg_en   = 1'b1;
        dbg_rdy  = 1'b1;
        overflow = 1'b0;
        drain(5000);

        chk("pop_total", n_pop, n_push);
        chk("final_vld", dbg_vld, 0);
        chk("final_empty", empty, 1);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
